// File: rtl/mem_pkg.sv
// Shared storage constants and address-width helper for mem_mod,
// fifo_ctrl and their benches.
package mem_pkg;
   localparam int MEM_DATA_WIDTH = 8;
   localparam int MEM_MAX_ADDR   = 4;

   function automatic int addr_size(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/mem_mod.sv
// Dual-port storage with one write port and a registered read port.
// rd_data holds its value between reads.
module mem_mod
   import mem_pkg::*;
#(
   parameter int  DATA_WIDTH = MEM_DATA_WIDTH,
   parameter int  MAX_ADDR   = MEM_MAX_ADDR,
   localparam int ADDRSIZE   = addr_size(MAX_ADDR)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDRSIZE-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDRSIZE-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);
   logic [DATA_WIDTH-1:0] mem_q [MAX_ADDR];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/fifo_ctrl.sv
// Circular-buffer FIFO controller around mem_mod: pointers, occupancy,
// full/empty flags and one-cycle drop pulses for rejected requests.
module fifo_ctrl
   import mem_pkg::*;
#(
   parameter int  DATA_WIDTH = MEM_DATA_WIDTH,
   parameter int  MAX_ADDR   = MEM_MAX_ADDR,
   localparam int ADDRSIZE   = addr_size(MAX_ADDR),
   localparam int CNTSIZE    = $clog2(MAX_ADDR + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pull,
   output logic [DATA_WIDTH-1:0] pull_data,
   output logic                  pull_valid,
   output logic                  full,
   output logic                  empty,
   output logic [CNTSIZE-1:0]    count,
   output logic                  push_drop,
   output logic                  pull_drop
);
   logic [ADDRSIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNTSIZE-1:0]  count_q, count_d;
   logic                pull_valid_q, push_drop_q, pull_drop_q;
   logic                push_ok, pull_ok;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [ADDRSIZE-1:0] ptr_inc(input logic [ADDRSIZE-1:0] p);
      return (p == ADDRSIZE'(MAX_ADDR - 1)) ? '0 : p + ADDRSIZE'(1);
   endfunction

   assign full    = (count_q == CNTSIZE'(MAX_ADDR));
   assign empty   = (count_q == '0);
   // Full rejects push even with a concurrent pull; empty rejects pull even
   // with a concurrent push, so no same-address read/write and no fall-through.
   assign push_ok = push & ~full;
   assign pull_ok = pull & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pull_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_ok, pull_ok})
         2'b10:   count_d = count_q + CNTSIZE'(1);
         2'b01:   count_d = count_q - CNTSIZE'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         pull_valid_q <= 1'b0;
         push_drop_q  <= 1'b0;
         pull_drop_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         pull_valid_q <= pull_ok;
         push_drop_q  <= push & full;
         pull_drop_q  <= pull & empty;
      end
   end

   mem_mod #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_ADDR   (MAX_ADDR)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr_q),
      .wr_data (push_data),
      .rd_en   (pull_ok),
      .rd_addr (rd_ptr_q),
      .rd_data (pull_data)
   );

   assign pull_valid = pull_valid_q;
   assign push_drop  = push_drop_q;
   assign pull_drop  = pull_drop_q;
   assign count      = count_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios on depth-4 and depth-3 instances,
// then randomized traffic against a queue-based reference model.
module tb_fifo_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       push4 = 1'b0, pull4 = 1'b0;
   logic [7:0] pdata4 = '0, qdata4;
   logic       pv4, full4, empty4, pushd4, pulld4;
   logic [2:0] count4;

   logic       push3 = 1'b0, pull3 = 1'b0;
   logic [7:0] pdata3 = '0, qdata3;
   logic       pv3, full3, empty3, pushd3, pulld3;
   logic [1:0] count3;

   int n_vec = 0;
   int n_err = 0;

   fifo_ctrl #(.DATA_WIDTH(8), .MAX_ADDR(4)) dut4 (
      .clk(clk), .rst(rst), .push(push4), .push_data(pdata4), .pull(pull4),
      .pull_data(qdata4), .pull_valid(pv4), .full(full4), .empty(empty4),
      .count(count4), .push_drop(pushd4), .pull_drop(pulld4));

   fifo_ctrl #(.DATA_WIDTH(8), .MAX_ADDR(3)) dut3 (
      .clk(clk), .rst(rst), .push(push3), .push_data(pdata3), .pull(pull3),
      .pull_data(qdata3), .pull_valid(pv3), .full(full3), .empty(empty3),
      .count(count3), .push_drop(pushd3), .pull_drop(pulld3));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; push4 = 1'b1; pull4 = 1'b1; pdata4 = 8'hEE;
      push3 = 1'b1; pull3 = 1'b1; pdata3 = 8'hEE;
      for (int i = 0; i < 2; i++) begin
         step();
         n_vec++; if (empty4 !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty4); end
         n_vec++; if (full4 !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full4); end
         n_vec++; if (count4 !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count4); end
         n_vec++; if (pv4 !== 1'b0) begin n_err++; $display("FAIL reset_pull_valid got %b exp 0", pv4); end
         n_vec++; if (count3 !== 2'd0) begin n_err++; $display("FAIL reset_count3 got %0d exp 0", count3); end
      end
      rst = 1'b0; push4 = 1'b0; pull4 = 1'b0; push3 = 1'b0; pull3 = 1'b0;
      step();
      // Nothing was written during reset: a pull now must be dropped.
      pull4 = 1'b1;
      step();
      pull4 = 1'b0;
      n_vec++; if (pulld4 !== 1'b1) begin n_err++; $display("FAIL reset_nowrite_drop got %b exp 1", pulld4); end
      n_vec++; if (pv4 !== 1'b0) begin n_err++; $display("FAIL reset_nowrite_valid got %b exp 0", pv4); end
      n_vec++; if (count4 !== 3'd0) begin n_err++; $display("FAIL reset_nowrite_count got %0d exp 0", count4); end
      step();
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 4; i++) begin
         push4 = 1'b1; pdata4 = 8'(5 + i);
         step();
         n_vec++; if (count4 !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count got %0d exp %0d", count4, i + 1); end
      end
      n_vec++; if (full4 !== 1'b1) begin n_err++; $display("FAIL fill_full got %b exp 1", full4); end
      pdata4 = 8'd9;
      step();
      push4 = 1'b0;
      n_vec++; if (pushd4 !== 1'b1) begin n_err++; $display("FAIL overflow_drop got %b exp 1", pushd4); end
      n_vec++; if (count4 !== 3'd4) begin n_err++; $display("FAIL overflow_count got %0d exp 4", count4); end
      step();
      n_vec++; if (pushd4 !== 1'b0) begin n_err++; $display("FAIL overflow_drop_pulse got %b exp 0", pushd4); end
   endtask

   task automatic test_drain_underflow();
      for (int i = 0; i < 4; i++) begin
         pull4 = 1'b1;
         step();
         n_vec++; if (pv4 !== 1'b1) begin n_err++; $display("FAIL drain_valid got %b exp 1", pv4); end
         n_vec++; if (qdata4 !== 8'(5 + i)) begin n_err++; $display("FAIL drain_data got %0d exp %0d", qdata4, 5 + i); end
      end
      n_vec++; if (empty4 !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b exp 1", empty4); end
      step();
      pull4 = 1'b0;
      n_vec++; if (pulld4 !== 1'b1) begin n_err++; $display("FAIL underflow_drop got %b exp 1", pulld4); end
      n_vec++; if (pv4 !== 1'b0) begin n_err++; $display("FAIL underflow_valid got %b exp 0", pv4); end
      step();
      n_vec++; if (pulld4 !== 1'b0) begin n_err++; $display("FAIL underflow_drop_pulse got %b exp 0", pulld4); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 7; i++) begin
         push3 = 1'b1; pdata3 = 8'(i);
         step();
         push3 = 1'b0;
         n_vec++; if (count3 !== 2'd1) begin n_err++; $display("FAIL wrap_count_push got %0d exp 1", count3); end
         pull3 = 1'b1;
         step();
         pull3 = 1'b0;
         n_vec++; if (pv3 !== 1'b1 || qdata3 !== 8'(i)) begin
            n_err++; $display("FAIL wrap_data got %0d/%b exp %0d/1", qdata3, pv3, i);
         end
         n_vec++; if (count3 !== 2'd0) begin n_err++; $display("FAIL wrap_count_pull got %0d exp 0", count3); end
      end
   endtask

   task automatic test_simultaneous();
      push4 = 1'b1; pdata4 = 8'hA0; step();
      pdata4 = 8'hA1; step();
      pdata4 = 8'hA2; pull4 = 1'b1; step();
      n_vec++; if (count4 !== 3'd2) begin n_err++; $display("FAIL sim_mid_count got %0d exp 2", count4); end
      n_vec++; if (pv4 !== 1'b1 || qdata4 !== 8'hA0) begin n_err++; $display("FAIL sim_mid_data got %h/%b exp a0/1", qdata4, pv4); end
      push4 = 1'b0; step(); step();
      n_vec++; if (qdata4 !== 8'hA2 || count4 !== 3'd0) begin n_err++; $display("FAIL sim_drain got %h cnt %0d exp a2 cnt 0", qdata4, count4); end
      push4 = 1'b1; pdata4 = 8'hB0; step();
      n_vec++; if (pulld4 !== 1'b1) begin n_err++; $display("FAIL sim_empty_drop got %b exp 1", pulld4); end
      n_vec++; if (count4 !== 3'd1 || pv4 !== 1'b0) begin n_err++; $display("FAIL sim_empty_count got %0d/%b exp 1/0", count4, pv4); end
      pull4 = 1'b0;
      for (int i = 1; i < 4; i++) begin pdata4 = 8'(8'hB0 + i); step(); end
      n_vec++; if (full4 !== 1'b1) begin n_err++; $display("FAIL sim_full got %b exp 1", full4); end
      pdata4 = 8'hCC; pull4 = 1'b1; step();
      push4 = 1'b0; pull4 = 1'b0;
      n_vec++; if (pushd4 !== 1'b1) begin n_err++; $display("FAIL sim_full_drop got %b exp 1", pushd4); end
      n_vec++; if (count4 !== 3'd3) begin n_err++; $display("FAIL sim_full_count got %0d exp 3", count4); end
      n_vec++; if (pv4 !== 1'b1 || qdata4 !== 8'hB0) begin n_err++; $display("FAIL sim_full_data got %h/%b exp b0/1", qdata4, pv4); end
   endtask

   task automatic test_reset_mid();
      // Entered with count = 3 from the previous scenario.
      pull4 = 1'b1; rst = 1'b1; step();
      pull4 = 1'b0; rst = 1'b0;
      n_vec++; if (pv4 !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b exp 0", pv4); end
      n_vec++; if (count4 !== 3'd0 || empty4 !== 1'b1) begin n_err++; $display("FAIL rstmid_count got %0d/%b exp 0/1", count4, empty4); end
      push4 = 1'b1; pdata4 = 8'h2A; step();
      push4 = 1'b0; pull4 = 1'b1; step();
      pull4 = 1'b0;
      n_vec++; if (pv4 !== 1'b1 || qdata4 !== 8'h2A) begin n_err++; $display("FAIL rstmid_data got %h/%b exp 2a/1", qdata4, pv4); end
      step();
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      logic [7:0] exp_d;
      logic       m_full, m_empty, exp_pv;
      int         bias;
      for (int i = 0; i < 600; i++) begin
         bias = (i < 200) ? 70 : (i < 400) ? 50 : 30;
         push4  = ($urandom_range(0, 99) < bias);
         pull4  = ($urandom_range(0, 99) < (100 - bias));
         pdata4 = 8'($urandom);
         m_full  = (q.size() == 4);
         m_empty = (q.size() == 0);
         exp_pv  = pull4 & ~m_empty;
         exp_d   = 8'h00;
         if (exp_pv) exp_d = q.pop_front();
         if (push4 && !m_full) q.push_back(pdata4);
         step();
         n_vec++; if (pv4 !== exp_pv) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, pv4, exp_pv); end
         if (exp_pv) begin
            n_vec++; if (qdata4 !== exp_d) begin n_err++; $display("FAIL rnd_data cyc %0d got %h exp %h", i, qdata4, exp_d); end
         end
         n_vec++; if (pushd4 !== (push4 & m_full)) begin n_err++; $display("FAIL rnd_push_drop cyc %0d got %b exp %b", i, pushd4, push4 & m_full); end
         n_vec++; if (pulld4 !== (pull4 & m_empty)) begin n_err++; $display("FAIL rnd_pull_drop cyc %0d got %b exp %b", i, pulld4, pull4 & m_empty); end
         n_vec++; if (count4 !== 3'(q.size())) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", i, count4, q.size()); end
         n_vec++; if (full4 !== (q.size() == 4) || empty4 !== (q.size() == 0)) begin
            n_err++; $display("FAIL rnd_flags cyc %0d got f%b e%b size %0d", i, full4, empty4, q.size());
         end
      end
      push4 = 1'b0; pull4 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_drain_underflow();
      test_wrap();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
